nts_engine_scheduler: RTL and testbench
=======================================

Name: nts_engine_scheduler

Overview:
- Round-robin scheduler that assigns each complete RX packet to one of ENGINES NTS engines, with a start/ack handshake, an engine-wait timeout and packet drop.
- Sits between the RX buffer stage and the engine array.
- Successor to fixed first-free engine selection: adds a parametrised engine count, a per-engine enable mask, a fair rotating grant, ack-timeout retry and saturating statistics.

Parameters:
- ENGINES, 12, number of engines (1..64).
- IDX_WIDTH, 6, width of the engine index; must satisfy 2^IDX_WIDTH >= ENGINES.
- TIMEOUT_WIDTH, 16, width of the wait/ack timeout counter.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_areset  in  1  reset; synchronous, active-high.
- i_pkt_valid  in  1  a complete packet is waiting; held until o_pkt_accept.
- o_pkt_accept  out  1  one-cycle pulse: the packet was dispatched or dropped.
- o_pkt_drop  out  1  one-cycle pulse coincident with o_pkt_accept when the packet is dropped.
- i_engine_ready  in  ENGINES  engine can take a packet.
- i_engine_enable  in  ENGINES  software enable mask.
- o_engine_start  out  ENGINES  one-hot start, held until ack or timeout.
- i_engine_ack  in  ENGINES  engine took the packet.
- i_timeout_cycles  in  TIMEOUT_WIDTH  wait/ack limit; 0 = never time out.
- o_grant_index  out  IDX_WIDTH  index of the last granted engine.
- o_busy  out  1  FSM not in IDLE.
- o_cnt_dispatched  out  CNT_WIDTH  packets dispatched.
- o_cnt_dropped  out  CNT_WIDTH  packets dropped.
- o_cnt_ack_timeout  out  CNT_WIDTH  start attempts aborted without ack.

Behaviour:
- Reset: every output 0, FSM IDLE, wait_ctr 0, rr pointer last = ENGINES-1, so the first grant search begins at engine 0. Reset mid-operation deasserts start within one cycle and produces no accept pulse.
- All outputs are registered.
- eligible = i_engine_ready & i_engine_enable.

FSM states:
- IDLE:
  - o_busy=0.
  - If i_pkt_valid and o_pkt_accept==0: go to SELECT, wait_ctr<=0.
  - While o_pkt_accept is high, i_pkt_valid is ignored; the producer may keep valid for that cycle.
- SELECT:
  - If i_pkt_valid=0: go to IDLE, no counters change (protocol violation, silently tolerated).
  - Else if eligible!=0: grant = first set bit of eligible scanning from last+1 upward, wrapping at ENGINES-1 to 0. Set o_engine_start<=1<<grant, o_grant_index<=grant, wait_ctr<=0, go to START.
  - Else if i_timeout_cycles!=0 and wait_ctr==i_timeout_cycles-1: o_pkt_accept<=1, o_pkt_drop<=1, cnt_dropped++, go to IDLE.
  - Else: wait_ctr++.
- START:
  - If i_engine_ack[grant]: start<=0, o_pkt_accept<=1, cnt_dispatched++, last<=grant, go to IDLE.
  - Else if i_timeout_cycles!=0 and wait_ctr==i_timeout_cycles-1: start<=0, cnt_ack_timeout++, last<=grant, wait_ctr<=0, go to SELECT. The retry skips the failed engine first.
  - Else: wait_ctr++.
  - Acks from non-granted engines are ignored.
  - A change in ready or enable during START does not abort the start.

Timing and arithmetic:
- Latency: valid rises at T; SELECT at T+1; start visible at T+2 if an engine is eligible. Ack sampled at T+k gives accept visible at T+k+1.
- Counters saturate at all-ones; they never wrap.
- wait_ctr saturates at all-ones when timeout=0.
- Single eligible engine equal to last: rr search wraps and grants it again.
- ENGINES=1: grant is always 0.

Optional Feature:
- Macro: NTS_ENGINE_SCHEDULER_STATS_EN.
- Defined: the three counters operate as specified.
- Undefined: the counter registers are not built; o_cnt_dispatched, o_cnt_dropped and o_cnt_ack_timeout are tied 0.
- FSM, handshake and timing are identical in both builds.

Test Plan:
- Reset, then ENGINES=4, ready=enable=4'b1111, three packets, each acked one cycle after start -> grants 0,1,2 in order; o_cnt_dispatched=3; first start at T+2 after valid.
- last=2, eligible=4'b0011 -> grant 0 (wrap past 3); next packet with eligible=4'b0001 -> grant 0 again.
- timeout=5, eligible=0 throughout -> accept+drop pulse 6 cycles after valid; o_cnt_dropped=1; no start ever asserted.
- timeout=3, engine 1 never acks, engine 2 eligible -> start[1] held 3 cycles, then start[2]; ack -> o_cnt_ack_timeout=1, o_cnt_dispatched=1, o_grant_index=2.
- timeout=0, eligible=0 for 1000 cycles, then ready[3]=1 -> no drop; start[3] asserted 1 cycle later.
- Assert reset while start[1] is high -> next cycle all outputs 0, FSM IDLE, counters 0; STATS_EN undefined build -> counters read 0 after 3 dispatches.

Source files
------------

// File: rtl/nts_engine_scheduler_if.sv
// Handshake bundle between the RX buffer stage, the engine array and the
// round-robin engine scheduler (master = environment, slave = scheduler).
interface nts_engine_scheduler_if #(
    parameter int ENGINES       = 12,
    parameter int IDX_WIDTH     = 6,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int CNT_WIDTH     = 32
);
    logic                     pkt_valid;
    logic                     pkt_accept;
    logic                     pkt_drop;
    logic [ENGINES-1:0]       engine_ready;
    logic [ENGINES-1:0]       engine_enable;
    logic [ENGINES-1:0]       engine_start;
    logic [ENGINES-1:0]       engine_ack;
    logic [TIMEOUT_WIDTH-1:0] timeout_cycles;
    logic [IDX_WIDTH-1:0]     grant_index;
    logic                     busy;
    logic [CNT_WIDTH-1:0]     cnt_dispatched;
    logic [CNT_WIDTH-1:0]     cnt_dropped;
    logic [CNT_WIDTH-1:0]     cnt_ack_timeout;

    modport master (
        output pkt_valid, engine_ready, engine_enable, engine_ack, timeout_cycles,
        input  pkt_accept, pkt_drop, engine_start, grant_index, busy,
               cnt_dispatched, cnt_dropped, cnt_ack_timeout
    );

    modport slave (
        input  pkt_valid, engine_ready, engine_enable, engine_ack, timeout_cycles,
        output pkt_accept, pkt_drop, engine_start, grant_index, busy,
               cnt_dispatched, cnt_dropped, cnt_ack_timeout
    );
endinterface

// File: rtl/nts_engine_scheduler.sv
// Round-robin packet-to-engine scheduler with start/ack handshake, wait/ack timeout and drop.
// Define NTS_ENGINE_SCHEDULER_STATS_EN to build the saturating statistics counters.
module nts_engine_scheduler #(
    parameter int ENGINES       = 12,
    parameter int IDX_WIDTH     = 6,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 areset,
    nts_engine_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SELECT, START} state_t;

    state_t                   state, state_nxt;
    logic [ENGINES-1:0]       eligible;
    logic [ENGINES-1:0]       start_q, start_nxt;
    logic [IDX_WIDTH-1:0]     grant_q, grant_nxt;
    logic [IDX_WIDTH-1:0]     last_q, last_nxt;
    logic [IDX_WIDTH-1:0]     rr_grant;
    logic [IDX_WIDTH:0]       rr_base;
    logic [ENGINES-1:0]       rr_rot;
    logic [TIMEOUT_WIDTH-1:0] wait_q, wait_nxt, wait_inc;
    logic                     accept_q, accept_nxt;
    logic                     drop_q, drop_nxt;
    logic                     busy_q;
    logic                     tmo_hit;
    logic                     ack_hit;

    assign eligible = bus.engine_ready & bus.engine_enable;
    assign tmo_hit  = (bus.timeout_cycles != '0) &&
                      (wait_q == bus.timeout_cycles - TIMEOUT_WIDTH'(1));
    assign wait_inc = (wait_q == '1) ? wait_q : wait_q + TIMEOUT_WIDTH'(1);
    // start is one-hot on the granted engine, so this ignores acks from others
    assign ack_hit  = |(bus.engine_ack & start_q);

    // Rotate eligible so bit 0 is the engine after last, then take the first set bit.
    always_comb begin
        int off;
        int sum;
        off     = 0;
        sum     = 0;
        rr_base = {1'b0, last_q} + (IDX_WIDTH+1)'(1);
        rr_rot  = ENGINES'({eligible, eligible} >> rr_base);
        for (int j = ENGINES - 1; j >= 0; j--) begin
            if (rr_rot[j]) off = j;
        end
        sum = int'(rr_base) + off;
        if (sum >= ENGINES) sum = sum - ENGINES;
        rr_grant = IDX_WIDTH'(sum);
    end

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        start_nxt  = start_q;
        grant_nxt  = grant_q;
        last_nxt   = last_q;
        wait_nxt   = wait_q;
        accept_nxt = 1'b0;
        drop_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.pkt_valid && !accept_q) begin
                    state_nxt = SELECT;
                    wait_nxt  = '0;
                end
            end
            SELECT: begin
                if (!bus.pkt_valid) begin
                    state_nxt = IDLE;
                end else if (|eligible) begin
                    start_nxt = ENGINES'(1) << rr_grant;
                    grant_nxt = rr_grant;
                    wait_nxt  = '0;
                    state_nxt = START;
                end else if (tmo_hit) begin
                    accept_nxt = 1'b1;
                    drop_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            START: begin
                if (ack_hit) begin
                    start_nxt  = '0;
                    accept_nxt = 1'b1;
                    last_nxt   = grant_q;
                    state_nxt  = IDLE;
                end else if (tmo_hit) begin
                    // retry from SELECT; updating last makes the search skip this engine first
                    start_nxt = '0;
                    last_nxt  = grant_q;
                    wait_nxt  = '0;
                    state_nxt = SELECT;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (areset) begin
            state    <= IDLE;
            start_q  <= '0;
            grant_q  <= '0;
            last_q   <= IDX_WIDTH'(ENGINES - 1);
            wait_q   <= '0;
            accept_q <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_q  <= start_nxt;
            grant_q  <= grant_nxt;
            last_q   <= last_nxt;
            wait_q   <= wait_nxt;
            accept_q <= accept_nxt;
            drop_q   <= drop_nxt;
            busy_q   <= (state_nxt != IDLE);
        end
    end

    assign bus.pkt_accept   = accept_q;
    assign bus.pkt_drop     = drop_q;
    assign bus.engine_start = start_q;
    assign bus.grant_index  = grant_q;
    assign bus.busy         = busy_q;

`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_disp_q, cnt_drop_q, cnt_ackto_q;
    logic                 inc_disp, inc_drop, inc_ackto;

    assign inc_disp  = (state == START) && ack_hit;
    assign inc_drop  = (state == SELECT) && bus.pkt_valid && !(|eligible) && tmo_hit;
    assign inc_ackto = (state == START) && !ack_hit && tmo_hit;

    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_disp_q  <= '0;
            cnt_drop_q  <= '0;
            cnt_ackto_q <= '0;
        end else begin
            if (inc_disp && cnt_disp_q != '1)   cnt_disp_q  <= cnt_disp_q + CNT_WIDTH'(1);
            if (inc_drop && cnt_drop_q != '1)   cnt_drop_q  <= cnt_drop_q + CNT_WIDTH'(1);
            if (inc_ackto && cnt_ackto_q != '1) cnt_ackto_q <= cnt_ackto_q + CNT_WIDTH'(1);
        end
    end

    assign bus.cnt_dispatched  = cnt_disp_q;
    assign bus.cnt_dropped     = cnt_drop_q;
    assign bus.cnt_ack_timeout = cnt_ackto_q;
`else
    assign bus.cnt_dispatched  = {CNT_WIDTH{1'b0}};
    assign bus.cnt_dropped     = {CNT_WIDTH{1'b0}};
    assign bus.cnt_ack_timeout = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_nts_engine_scheduler.sv
// Self-checking bench for nts_engine_scheduler: directed scenarios plus randomized
// packets checked against a round-robin reference model of grants and counters.
module tb_nts_engine_scheduler;
    localparam int ENGINES       = 4;
    localparam int IDX_WIDTH     = 2;
    localparam int TIMEOUT_WIDTH = 16;
    localparam int CNT_WIDTH     = 32;
    localparam int LIMIT         = 200;

    logic clk    = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    nts_engine_scheduler_if #(
        .ENGINES(ENGINES), .IDX_WIDTH(IDX_WIDTH),
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    nts_engine_scheduler #(
        .ENGINES(ENGINES), .IDX_WIDTH(IDX_WIDTH),
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .areset(areset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_last  = ENGINES - 1;
    int m_disp  = 0;
    int m_drop  = 0;
    int m_ackto = 0;
    int start_times[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // first eligible engine after 'last', scanning upward with wrap
    function automatic int next_grant(input logic [ENGINES-1:0] elig, input int last);
        for (int i = 1; i <= ENGINES; i++) begin
            if (elig[(last + i) % ENGINES]) return (last + i) % ENGINES;
        end
        return -1;
    endfunction

    task automatic check_counters(input string tag);
`ifdef NTS_ENGINE_SCHEDULER_STATS_EN
        check({tag, " cnt_dispatched"}, bus.cnt_dispatched, m_disp);
        check({tag, " cnt_dropped"}, bus.cnt_dropped, m_drop);
        check({tag, " cnt_ack_timeout"}, bus.cnt_ack_timeout, m_ackto);
`else
        check({tag, " cnt_dispatched"}, bus.cnt_dispatched, 0);
        check({tag, " cnt_dropped"}, bus.cnt_dropped, 0);
        check({tag, " cnt_ack_timeout"}, bus.cnt_ack_timeout, 0);
`endif
    endtask

    // One packet: model predicts the sequence of start attempts and the outcome,
    // then the bus is driven and each attempt and the final accept are compared.
    task automatic send_packet(input string tag, input logic [ENGINES-1:0] rdy,
                               input logic [ENGINES-1:0] en, input logic [ENGINES-1:0] dead,
                               input int tmo, input int ack_after,
                               output int t_first_start, output int t_accept);
        logic [ENGINES-1:0] elig;
        int                 exp_q[$];
        bit                 exp_drop;
        bit                 done;
        int                 g;
        int                 cyc;
        int                 since;
        int                 cur;
        logic [ENGINES-1:0] prev;
        elig     = rdy & en;
        exp_drop = (elig == '0);
        g        = m_last;
        if (!exp_drop) begin
            for (int a = 0; a < 16; a++) begin
                g = next_grant(elig, g);
                exp_q.push_back(g);
                if (!dead[g]) break;
                m_ackto++;
            end
            m_disp++;
            m_last = g;
        end else begin
            m_drop++;
        end

        start_times.delete();
        t_first_start = -1;
        t_accept      = -1;
        done  = 1'b0;
        cyc   = 0;
        since = 0;
        cur   = -1;
        prev  = '0;
        bus.engine_ready   = rdy;
        bus.engine_enable  = en;
        bus.timeout_cycles = TIMEOUT_WIDTH'(tmo);
        bus.pkt_valid      = 1'b1;
        while (!done && cyc < LIMIT) begin
            step();
            cyc++;
            bus.engine_ack = '0;
            if (bus.engine_start != '0 && prev == '0) begin
                start_times.push_back(cyc);
                since = 0;
                if (t_first_start < 0) t_first_start = cyc;
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected start"}, bus.engine_start, 0);
                    cur = -1;
                end else begin
                    cur = exp_q.pop_front();
                    check({tag, " start onehot"}, bus.engine_start, 64'(1) << cur);
                    check({tag, " grant_index"}, bus.grant_index, cur);
                end
            end else if (bus.engine_start != '0) begin
                since++;
            end
            prev = bus.engine_start;
            if (bus.pkt_accept) begin
                done     = 1'b1;
                t_accept = cyc;
                check({tag, " drop flag"}, bus.pkt_drop, exp_drop);
            end else if (bus.engine_start != '0 && cur >= 0 && !dead[cur] && since == ack_after) begin
                bus.engine_ack = bus.engine_start;
            end
        end
        check({tag, " accept seen"}, done, 1);
        check({tag, " attempts left"}, exp_q.size(), 0);
        bus.pkt_valid    = 1'b0;
        bus.engine_ready = '0;
        step();
        check({tag, " accept one cycle"}, bus.pkt_accept, 0);
        check({tag, " idle after"}, bus.busy, 0);
    endtask

    initial begin
        int t_start;
        int t_acc;
        int cnt_a;
        int cnt_s;
        int g;
        logic [ENGINES-1:0] rdy;
        logic [ENGINES-1:0] en;
        logic [ENGINES-1:0] dead;
        int tmo;

        bus.pkt_valid      = 1'b0;
        bus.engine_ready   = '0;
        bus.engine_enable  = '0;
        bus.engine_ack     = '0;
        bus.timeout_cycles = '0;

        // reset state
        step();
        step();
        check("rst accept", bus.pkt_accept, 0);
        check("rst drop", bus.pkt_drop, 0);
        check("rst start", bus.engine_start, 0);
        check("rst grant", bus.grant_index, 0);
        check("rst busy", bus.busy, 0);
        check_counters("rst");
        areset = 1'b0;
        step();

        // three packets with everything eligible: grants 0,1,2, first start at T+2
        for (int p = 0; p < 3; p++) begin
            send_packet("rr", 4'b1111, 4'b1111, 4'b0000, 0, 1, t_start, t_acc);
            check("rr grant order", bus.grant_index, p);
            if (p == 0) check("rr start latency", t_start, 2);
        end
        check_counters("rr");

        // wrap past engine 3, then single eligible equal to last
        send_packet("wrap", 4'b0011, 4'b1111, 4'b0000, 0, 0, t_start, t_acc);
        check("wrap grant", bus.grant_index, 0);
        send_packet("same", 4'b1111, 4'b0001, 4'b0000, 0, 2, t_start, t_acc);
        check("same grant", bus.grant_index, 0);

        // nothing eligible with timeout 5: drop 6 cycles after valid, no start
        send_packet("drop", 4'b0000, 4'b1111, 4'b0000, 5, 0, t_start, t_acc);
        check("drop latency", t_acc, 6);
        check("drop no start", start_times.size(), 0);
        check_counters("drop");

        // engine 1 never acks, timeout 3: held 3 cycles, then engine 2 takes it
        send_packet("ackto", 4'b0110, 4'b1111, 4'b0010, 3, 1, t_start, t_acc);
        check("ackto attempts", start_times.size(), 2);
        if (start_times.size() == 2) check("ackto hold", start_times[1] - start_times[0], 4);
        check("ackto grant", bus.grant_index, 2);
        check_counters("ackto");

        // timeout 0: wait forever without dropping, then start one cycle after ready
        bus.engine_ready   = 4'b0000;
        bus.engine_enable  = 4'b1111;
        bus.timeout_cycles = '0;
        bus.pkt_valid      = 1'b1;
        cnt_a = 0;
        cnt_s = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.pkt_accept) cnt_a++;
            if (bus.engine_start != '0) cnt_s++;
        end
        check("tmo0 no accept", cnt_a, 0);
        check("tmo0 no start", cnt_s, 0);
        check("tmo0 busy", bus.busy, 1);
        bus.engine_ready = 4'b1000;
        g = next_grant(4'b1000, m_last);
        step();
        check("tmo0 late start", bus.engine_start, 64'(1) << g);
        bus.engine_ack = 4'b1000;
        step();
        bus.engine_ack = '0;
        check("tmo0 accept", bus.pkt_accept, 1);
        check("tmo0 drop", bus.pkt_drop, 0);
        m_last = g;
        m_disp++;
        bus.pkt_valid    = 1'b0;
        bus.engine_ready = '0;
        step();

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            en   = 4'($urandom);
            rdy  = 4'($urandom);
            tmo  = int'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                rdy  = '0;
                dead = '0;
            end else begin
                if ((rdy & en) == '0) begin
                    g = int'($urandom_range(0, ENGINES - 1));
                    rdy[g] = 1'b1;
                    en[g]  = 1'b1;
                end
                dead = 4'($urandom) & rdy & en;
                if (dead == (rdy & en)) dead = dead & ~((rdy & en) & (~(rdy & en) + 4'd1));
            end
            send_packet("rand", rdy, en, dead, tmo, int'($urandom_range(0, tmo - 1)), t_start, t_acc);
            if ((rdy & en) == '0) check("rand drop latency", t_acc, tmo + 1);
        end
        check_counters("rand");

        // reset while start[1] is held
        bus.engine_ready   = 4'b0010;
        bus.engine_enable  = 4'b1111;
        bus.timeout_cycles = '0;
        bus.pkt_valid      = 1'b1;
        for (int i = 0; i < 10 && bus.engine_start == '0; i++) step();
        check("midrst start before", bus.engine_start, 4'b0010);
        areset = 1'b1;
        step();
        check("midrst start", bus.engine_start, 0);
        check("midrst accept", bus.pkt_accept, 0);
        check("midrst drop", bus.pkt_drop, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst grant", bus.grant_index, 0);
        m_last  = ENGINES - 1;
        m_disp  = 0;
        m_drop  = 0;
        m_ackto = 0;
        check_counters("midrst");
        bus.pkt_valid    = 1'b0;
        bus.engine_ready = '0;
        areset = 1'b0;
        step();
        check("midrst idle", bus.busy, 0);

        // rr pointer restarts at 0 after reset; counters track three dispatches
        for (int p = 0; p < 3; p++) begin
            send_packet("post", 4'b1111, 4'b1111, 4'b0000, 0, 1, t_start, t_acc);
            check("post grant order", bus.grant_index, p);
        end
        check_counters("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
